// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: op encodings, latencies, FSM states.
package mdu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 4;

    localparam int unsigned DEF_MUL_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES = 10;

    localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_arith.sv
// Combinational signed/unsigned 32x32 multiply and divide producing a {hi, lo} pair.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0] md_op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div0
);

    logic [2*XLEN-1:0] w_prod_s;
    logic [2*XLEN-1:0] w_prod_u;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN-1:0]   w_b_safe;
    logic [XLEN-1:0]   w_q_mag;
    logic [XLEN-1:0]   w_r_mag;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign w_prod_s = {{XLEN{A[XLEN-1]}}, A} * {{XLEN{B[XLEN-1]}}, B};
    assign w_prod_u = {{XLEN{1'b0}}, A} * {{XLEN{1'b0}}, B};

    // Signed divide runs on magnitudes, then fixes signs: quotient truncates toward zero.
    assign w_a_neg  = (md_op == MD_DIV) && A[XLEN-1];
    assign w_b_neg  = (md_op == MD_DIV) && B[XLEN-1];
    assign w_a_mag  = w_a_neg ? XLEN'(-A) : A;
    assign w_b_mag  = w_b_neg ? XLEN'(-B) : B;
    assign w_b_safe = (B == '0) ? XLEN'(1) : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;

    always_comb begin
        hi   = '0;
        lo   = '0;
        div0 = ((md_op == MD_DIV) || (md_op == MD_DIVU)) && (B == '0);
        case (md_op)
            MD_MULT:  {hi, lo} = w_prod_s;
            MD_MULTU: {hi, lo} = w_prod_u;
            MD_DIV: begin
                lo = (w_a_neg ^ w_b_neg) ? XLEN'(-w_q_mag) : w_q_mag;
                hi = w_a_neg ? XLEN'(-w_r_mag) : w_r_mag;
            end
            MD_DIVU: begin
                lo = w_q_mag;
                hi = w_r_mag;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: latches results on start, holds busy for the op latency, commits HI/LO, raises stall.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] md_op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            id_md_use,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO,
    output logic            busy,
    output logic            stall
);

    mdu_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_phi;
    logic [XLEN-1:0]  r_plo;
    logic             r_div0;

    logic [XLEN-1:0]  w_hi;
    logic [XLEN-1:0]  w_lo;
    logic             w_div0;
    logic             w_is_arith;

    mdu_arith u_arith (
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .hi    (w_hi),
        .lo    (w_lo),
        .div0  (w_div0)
    );

    assign w_is_arith = (md_op <= MD_DIVU);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
            r_div0  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_is_arith) begin
                            r_phi   <= w_hi;
                            r_plo   <= w_lo;
                            r_div0  <= w_div0;
                            r_cnt   <= (md_op <= MD_MULTU) ? CNT_W'(MUL_CYCLES)
                                                           : CNT_W'(DIV_CYCLES);
                            r_state <= ST_BUSY;
                        end else if (md_op == MD_MTHI) begin
                            r_hi <= A;
                        end else if (md_op == MD_MTLO) begin
                            r_lo <= A;
                        end
                    end
                end
                // A start arriving here is dropped; the pipeline holds it off via stall.
                ST_BUSY: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        if (!r_div0) begin
                            r_hi <= r_phi;
                            r_lo <= r_plo;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign HI    = r_hi;
    assign LO    = r_lo;
    assign busy  = (r_state == ST_BUSY);
    assign stall = id_md_use & (busy | (start & w_is_arith));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, corner sequences, randomized ops vs. a reference model.
module tb_mdu_ctrl;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        id_md_use;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .md_op     (md_op),
        .A         (A),
        .B         (B),
        .id_md_use (id_md_use),
        .HI        (HI),
        .LO        (LO),
        .busy      (busy),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        use_id;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic int latency(input logic [2:0] op);
        if (op <= 3'd1) return MUL_N;
        if (op <= 3'd3) return DIV_N;
        return 0;
    endfunction

    // Architectural effect of one op on HI/LO, straight from the MIPS definitions.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            3'd2: if (b != 0) begin
                sq = sa / sb; sr = sa % sb;
                lo = sq[31:0]; hi = sr[31:0];
            end
            3'd3: if (b != 0) begin lo = a / b; hi = a % b; end
            3'd4: hi = a;
            3'd5: lo = a;
            default: ;
        endcase
    endtask

    // Issue one op at cycle 0, then check busy/stall per cycle and the commit at cycle N+1.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_id, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        n = latency(op);
        start = 1'b1; md_op = op; A = a; B = b; id_md_use = use_id;
        #1;
        check("stall_c0", 32'(stall), 32'(use_id && op <= 3'd3));
        cyc();
        start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            check("busy_in", 32'(busy), 32'd1);
            check("stall_in", 32'(stall), 32'(use_id));
            if (k == n) begin
                check("hi_pre", HI, m_hi);
                check("lo_pre", LO, m_lo);
            end
            cyc();
        end
        if (n == 0) id_md_use = 1'b0;
        check("busy_done", 32'(busy), 32'd0);
        check("stall_done", 32'(stall), 32'(0));
        check("hi_commit", HI, exp_hi);
        check("lo_commit", LO, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
        id_md_use = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, eh, el;

        vecs[0] = '{3'd0, 32'hFFFFFFFD, 32'd5,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1] = '{3'd0, 32'hFFFFFFFD, 32'd5,          1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{3'd3, 32'd17,       32'd5,          1'b0, 32'd2,        32'd3};
        vecs[3] = '{3'd2, 32'hFFFFFFF9, 32'd2,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{3'd1, 32'hFFFFFFFF, 32'd2,          1'b0, 32'd1,        32'hFFFFFFFE};
        vecs[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF,   1'b0, 32'd0,        32'h80000000};
        vecs[6] = '{3'd2, 32'd7,        32'hFFFFFFFE,   1'b0, 32'd1,        32'hFFFFFFFD};
        vecs[7] = '{3'd0, 32'h80000000, 32'h80000000,   1'b0, 32'h40000000, 32'd0};
        vecs[8] = '{3'd4, 32'h12345678, 32'd0,          1'b1, 32'h12345678, 32'h40000000 & 32'd0};
        vecs[9] = '{3'd5, 32'h9ABCDEF0, 32'd0,          1'b1, 32'h12345678, 32'h9ABCDEF0};

        // Reset with a start pending: stall follows the start term, reset wins over start.
        rst = 1'b1; start = 1'b1; md_op = 3'd0; A = 32'd3; B = 32'd4; id_md_use = 1'b1;
        cyc();
        #1;
        check("rst_stall", 32'(stall), 32'd1);
        cyc();
        rst = 1'b0; start = 1'b0; id_md_use = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_stall_idle", 32'(stall), 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        cyc();

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_id, vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // Divide by zero leaves preset HI/LO untouched.
        run_op(3'd4, 32'd1, 32'd0, 1'b0, 32'd1, m_lo);
        run_op(3'd5, 32'd2, 32'd0, 1'b0, 32'd1, 32'd2);
        run_op(3'd2, 32'd1234, 32'd0, 1'b1, 32'd1, 32'd2);
        run_op(3'd3, 32'd99, 32'd0, 1'b0, 32'd1, 32'd2);

        // mtlo while busy is dropped entirely.
        start = 1'b1; md_op = 3'd0; A = 32'd6; B = 32'd7;
        cyc();
        start = 1'b0;
        cyc();
        start = 1'b1; md_op = 3'd5; A = 32'hDEADBEEF;
        cyc();
        start = 1'b0;
        check("ign_lo", LO, 32'd2);
        check("ign_busy", 32'(busy), 32'd1);
        repeat (MUL_N - 2) cyc();
        check("ign_commit_busy", 32'(busy), 32'd0);
        check("ign_commit_lo", LO, 32'd42);
        check("ign_commit_hi", HI, 32'd0);
        cyc();
        check("ign_after_lo", LO, 32'd42);
        m_hi = 32'd0;
        m_lo = 32'd42;

        // Reset mid-divide discards the pending result.
        start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_hi", HI, 32'd0);
        check("mid_rst_lo", LO, 32'd0);
        repeat (DIV_N + 2) cyc();
        check("mid_rst_no_commit_hi", HI, 32'd0);
        check("mid_rst_no_commit_lo", LO, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        run_op(3'd0, 32'd11, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEA);

        // Randomized ops against the reference model.
        for (int t = 0; t < 40; t++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
            eh = m_hi;
            el = m_lo;
            model(op, a, b, eh, el);
            run_op(op, a, b, 1'($urandom_range(0, 1)), eh, el);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
